// File: rtl/pio_pkg.sv
// Definitions shared by the state-machine control blocks: FSM state type,
// delay/side-set field width and the delay-mask helper.
package pio_pkg;

   localparam int DELAY_W      = 5;
   localparam int SIDESET_MAX  = 5;

   typedef enum logic {
      EXEC  = 1'b0,
      DELAY = 1'b1
   } state_e;

   // Side-set bits occupy the top of the shared field; whatever remains below is delay.
   function automatic logic [DELAY_W-1:0] delay_mask(input logic [2:0] sideset_bits);
      logic [2:0] ss;
      ss = (sideset_bits > 3'(SIDESET_MAX)) ? 3'(SIDESET_MAX) : sideset_bits;
      return {DELAY_W{1'b1}} >> ss;
   endfunction

endpackage

// File: rtl/stall_ctrl.sv
// Stall generator for one state machine: merges the instruction's blocking
// condition with the post-instruction delay countdown and drives the PC stall.
module stall_ctrl
   import pio_pkg::*;
#(
   parameter int DELAY_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               penable,
   input  logic               imm,
   input  logic               restart,
   input  logic               blocked,
   input  logic [DELAY_W-1:0] delay_field,
   input  logic [2:0]         sideset_bits,
   output logic               stalled,
   output logic               delaying,
   output logic [DELAY_W-1:0] delay_cnt,
   output logic               advance
);

   state_e             state_q, state_d;
   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic [DELAY_W-1:0] eff_delay;
   logic               in_delay;

   assign eff_delay = delay_field & DELAY_W'(delay_mask(sideset_bits));
   assign in_delay  = (state_q == DELAY);

   // A forced instruction ignores any pending delay but still honours its own blocking condition.
   assign stalled   = blocked | (in_delay & ~imm);
   assign advance   = (penable | imm) & ~stalled;
   assign delaying  = in_delay;
   assign delay_cnt = cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (restart) begin
         state_d = EXEC;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            EXEC: begin
               if (advance && (eff_delay != '0)) begin
                  state_d = DELAY;
                  cnt_d   = eff_delay;
               end
            end
            DELAY: begin
               if (imm) begin
                  // New delay replaces the remainder; a forced zero-delay ends the wait.
                  if (!blocked) begin
                     if (eff_delay != '0) begin
                        cnt_d = eff_delay;
                     end else begin
                        state_d = EXEC;
                        cnt_d   = '0;
                     end
                  end
               end else if (penable && (cnt_q != '0)) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == DELAY_W'(1)) begin
                     state_d = EXEC;
                  end
               end
            end
            default: begin
               state_d = EXEC;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EXEC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   a_no_zero_in_delay: assert property (@(posedge clk) disable iff (reset)
      (state_q == DELAY) |-> (cnt_q != '0))
      else $error("stall_ctrl: delay counter is zero in DELAY state");

   a_exec_cnt_clear: assert property (@(posedge clk) disable iff (reset)
      (state_q == EXEC) |-> (cnt_q == '0))
      else $error("stall_ctrl: delay counter nonzero in EXEC state");

   a_no_wrap: assert property (@(posedge clk) disable iff (reset || restart)
      (state_q == DELAY && !imm && penable) |=> (cnt_q == $past(cnt_q) - 1'b1))
      else $error("stall_ctrl: delay counter did not step down by one");

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed testbench for stall_ctrl: delay countdown, side-set masking,
// penable gating, blocking, forced instructions, reset/restart.
module tb_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset, penable, imm, restart, blocked;
   logic [4:0] delay_field;
   logic [2:0] sideset_bits;
   logic       stalled, delaying, advance;
   logic [4:0] delay_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stall_ctrl #(.DELAY_W(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .penable      (penable),
      .imm          (imm),
      .restart      (restart),
      .blocked      (blocked),
      .delay_field  (delay_field),
      .sideset_bits (sideset_bits),
      .stalled      (stalled),
      .delaying     (delaying),
      .delay_cnt    (delay_cnt),
      .advance      (advance)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle past the edge before anything is sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic st, input logic dl,
                              input int cnt, input logic adv);
      check({tag, ".stalled"},   32'(stalled),   32'(st));
      check({tag, ".delaying"},  32'(delaying),  32'(dl));
      check({tag, ".delay_cnt"}, 32'(delay_cnt), 32'(cnt));
      check({tag, ".advance"},   32'(advance),   32'(adv));
   endtask

   initial begin
      reset = 1'b1; penable = 1'b0; imm = 1'b0; restart = 1'b0; blocked = 1'b0;
      delay_field = 5'd0; sideset_bits = 3'd0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check_state("reset", 1'b0, 1'b0, 0, 1'b0);

      // Reset in the middle of a 7-cycle delay
      delay_field = 5'h07; sideset_bits = 3'd0; penable = 1'b1;
      #1;
      check_state("rst_mid.issue", 1'b0, 1'b0, 0, 1'b1);
      tick();
      delay_field = 5'd0;
      #1;
      check_state("rst_mid.c1", 1'b1, 1'b1, 7, 1'b0);
      tick();
      check_state("rst_mid.c2", 1'b1, 1'b1, 6, 1'b0);
      tick();
      check_state("rst_mid.c3", 1'b1, 1'b1, 5, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check_state("rst_mid.after", 1'b0, 1'b0, 0, 1'b1);
      $display("txn reset_mid_delay done");

      // Side-set masking: 5'b11011 with 2 side-set bits -> 3 delay cycles
      delay_field = 5'b11011; sideset_bits = 3'd2; penable = 1'b1;
      #1;
      check("mask.issue_adv", 32'(advance), 32'd1);
      tick();
      delay_field = 5'd0; sideset_bits = 3'd0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_state($sformatf("mask.d%0d", i), 1'b1, 1'b1, 3 - i, 1'b0);
         tick();
      end
      check_state("mask.end", 1'b0, 1'b0, 0, 1'b1);
      tick();
      $display("txn sideset_mask done");

      // penable gating: delay 4 stretched over 8 clocks
      delay_field = 5'd4; penable = 1'b1;
      #1;
      check("gate.issue_adv", 32'(advance), 32'd1);
      tick();
      delay_field = 5'd0;
      for (int k = 0; k < 8; k++) begin
         penable = (k % 2 == 1);
         #1;
         check_state($sformatf("gate.k%0d", k), 1'b1, 1'b1, 4 - k / 2, 1'b0);
         tick();
      end
      penable = 1'b1;
      #1;
      check_state("gate.end", 1'b0, 1'b0, 0, 1'b1);
      tick();
      $display("txn penable_gating done");

      // Blocking for 5 cycles, then completion with delay 2
      blocked = 1'b1; delay_field = 5'd2; penable = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check_state($sformatf("blk.b%0d", i), 1'b1, 1'b0, 0, 1'b0);
         tick();
      end
      blocked = 1'b0;
      #1;
      check_state("blk.release", 1'b0, 1'b0, 0, 1'b1);
      tick();
      delay_field = 5'd0;
      #1;
      check_state("blk.d0", 1'b1, 1'b1, 2, 1'b0);
      tick();
      check_state("blk.d1", 1'b1, 1'b1, 1, 1'b0);
      tick();
      check_state("blk.end", 1'b0, 1'b0, 0, 1'b1);
      tick();
      $display("txn blocking done");

      // Forced instruction with zero delay cancels a pending delay
      delay_field = 5'd6; penable = 1'b1;
      tick();
      delay_field = 5'd0; penable = 1'b0;
      #1;
      check_state("imm0.loaded", 1'b1, 1'b1, 6, 1'b0);
      imm = 1'b1;
      #1;
      check_state("imm0.force", 1'b0, 1'b1, 6, 1'b1);
      tick();
      imm = 1'b0;
      #1;
      check_state("imm0.after", 1'b0, 1'b0, 0, 1'b0);
      $display("txn imm_zero_delay done");

      // Forced instruction with delay 3 replaces the remainder
      delay_field = 5'd6; penable = 1'b1;
      tick();
      delay_field = 5'd3; penable = 1'b0; imm = 1'b1;
      #1;
      check_state("imm3.force", 1'b0, 1'b1, 6, 1'b1);
      tick();
      imm = 1'b0; delay_field = 5'd0;
      #1;
      check_state("imm3.after", 1'b1, 1'b1, 3, 1'b0);
      penable = 1'b1;
      tick(); tick(); tick();
      check_state("imm3.drained", 1'b0, 1'b0, 0, 1'b1);
      $display("txn imm_reload_delay done");

      // Restart while delaying and blocked
      delay_field = 5'd5; penable = 1'b1;
      tick();
      delay_field = 5'd0; blocked = 1'b1; restart = 1'b1;
      #1;
      check("rst.pre_stalled", 32'(stalled), 32'd1);
      tick();
      restart = 1'b0;
      #1;
      check_state("restart.after", 1'b1, 1'b0, 0, 1'b0);
      blocked = 1'b0;
      $display("txn restart done");

      // Full-scale delay of 31 cycles
      delay_field = 5'h1F; sideset_bits = 3'd0; penable = 1'b1;
      #1;
      check("max.issue_adv", 32'(advance), 32'd1);
      tick();
      delay_field = 5'd0;
      #1;
      for (int i = 0; i < 31; i++) begin
         check_state($sformatf("max.d%0d", i), 1'b1, 1'b1, 31 - i, 1'b0);
         tick();
      end
      check_state("max.end", 1'b0, 1'b0, 0, 1'b1);
      $display("txn full_scale_delay done");

      // Side-set counts of 5 and above leave no delay bits
      delay_field = 5'h1F; sideset_bits = 3'd5;
      tick();
      check_state("ss5", 1'b0, 1'b0, 0, 1'b1);
      sideset_bits = 3'd7;
      tick();
      check_state("ss7_clamp", 1'b0, 1'b0, 0, 1'b1);
      sideset_bits = 3'd4;
      tick();
      delay_field = 5'd0;
      #1;
      check_state("ss4", 1'b1, 1'b1, 1, 1'b0);
      tick();
      check_state("ss4.end", 1'b0, 1'b0, 0, 1'b1);
      $display("txn sideset_clamp done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
